// File: rtl/commutation_generator_if.sv
// ---------------------------------------------------------------------------
// commutation_generator_if
//   Command and gate-output bundle of the six-step commutation generator.
//   master : speed/direction commander (drives speed_in, speed_load, dir)
//   slave  : commutation_generator (drives gate commands, step and ticks)
//   Signals:
//     speed_in[7:0]   commanded speed in rev/s (0 = coast)
//     speed_load      one-cycle strobe capturing speed_in
//     dir             0 = forward, 1 = reverse
//     HA,HB,HC        high-side switch commands
//     LA,LB,LC        low-side switch commands
//     step[2:0]       current commutation step 0..5
//     step_tick       one-cycle pulse per step advance
//     rev_tick        one-cycle pulse when step enters 0
// ---------------------------------------------------------------------------
interface commutation_generator_if;
    logic [7:0] speed_in;
    logic       speed_load;
    logic       dir;
    logic       HA;
    logic       HB;
    logic       HC;
    logic       LA;
    logic       LB;
    logic       LC;
    logic [2:0] step;
    logic       step_tick;
    logic       rev_tick;

    modport master (
        output speed_in, speed_load, dir,
        input  HA, HB, HC, LA, LB, LC, step, step_tick, rev_tick
    );

    modport slave (
        input  speed_in, speed_load, dir,
        output HA, HB, HC, LA, LB, LC, step, step_tick, rev_tick
    );
endinterface

// File: rtl/commutation_generator.sv
// ---------------------------------------------------------------------------
// commutation_generator
//   Six-step BLDC gate-pattern generator. A phase accumulator adds
//   6*speed each clock modulo CLK_HZ; every wrap advances the commutation
//   step, giving an exact average rate of 6*speed steps per second.
//   speed = 0 coasts: all gates off, accumulator and step frozen.
//
//   Ports:
//     clk  system clock
//     rst  asynchronous active-high reset
//     bus  commutation_generator_if.slave (speed/dir in; gates, step, ticks out)
//
//   Parameters:
//     CLK_HZ       clock frequency in Hz, accumulator modulus
//     ACC_W        accumulator width, CLK_HZ + 6*255 < 2**ACC_W
//     DEAD_CYCLES  turn-on delay of a newly enabled switch (1..255)
//
//   Build option:
//     DEADTIME_EN  when defined, an 8-bit down-counter holds off the incoming
//                  switch for DEAD_CYCLES clocks after each advance and after
//                  leaving coast; the outgoing switch always drops at once.
//                  When undefined, gates are a registered decode of the step.
// ---------------------------------------------------------------------------
module commutation_generator #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int ACC_W       = 26,
    parameter int DEAD_CYCLES = 50
) (
    input  logic                   clk,
    input  logic                   rst,
    commutation_generator_if.slave bus
);

    typedef enum logic [2:0] {
        STEP0 = 3'd0,
        STEP1 = 3'd1,
        STEP2 = 3'd2,
        STEP3 = 3'd3,
        STEP4 = 3'd4,
        STEP5 = 3'd5
    } step_t;

    localparam logic [ACC_W-1:0] MODULUS = ACC_W'(CLK_HZ);

    if (DEAD_CYCLES < 1 || DEAD_CYCLES > 255) begin : g_bad_dead
        $error("commutation_generator: DEAD_CYCLES must be 1..255");
    end
    if (longint'(CLK_HZ) + 64'd1530 >= (64'd1 << ACC_W)) begin : g_bad_acc
        $error("commutation_generator: ACC_W too small for CLK_HZ");
    end

    // Gate vector order: {HA, HB, HC, LA, LB, LC}
    logic [7:0]       speed_q;
    logic [10:0]      inc;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] sum;
    step_t            step_q;
    step_t            step_d;
    logic             running;
    logic             adv;
    logic [5:0]       target;
    logic [5:0]       gates_q;
    logic [5:0]       gates_d;
    logic             step_tick_q;
    logic             rev_tick_q;

`ifdef DEADTIME_EN
    localparam logic [7:0] DEAD = 8'(DEAD_CYCLES);
    logic [7:0] dt_q;
    logic [7:0] dt_d;
    logic       coast_q;
`endif

    // ------------------------------------------------------------------
    // Next-state: accumulator, step sequencing and gate decode
    // ------------------------------------------------------------------
    always_comb begin
        running = (speed_q != '0);
        inc     = {1'b0, speed_q, 2'b00} + {2'b00, speed_q, 1'b0};
        sum     = acc_q + ACC_W'(inc);
        adv     = 1'b0;
        acc_d   = acc_q;
        step_d  = step_q;
        target  = '0;

        if (running) begin
            if (sum >= MODULUS) begin
                adv   = 1'b1;
                acc_d = sum - MODULUS;
            end else begin
                acc_d = sum;
            end
        end

        if (adv) begin
            case (step_q)
                STEP0:   step_d = bus.dir ? STEP5 : STEP1;
                STEP1:   step_d = bus.dir ? STEP0 : STEP2;
                STEP2:   step_d = bus.dir ? STEP1 : STEP3;
                STEP3:   step_d = bus.dir ? STEP2 : STEP4;
                STEP4:   step_d = bus.dir ? STEP3 : STEP5;
                STEP5:   step_d = bus.dir ? STEP4 : STEP0;
                default: step_d = STEP0;
            endcase
        end

        case (step_d)
            STEP0:   target = 6'b100_010;  // HA, LB
            STEP1:   target = 6'b100_001;  // HA, LC
            STEP2:   target = 6'b010_001;  // HB, LC
            STEP3:   target = 6'b010_100;  // HB, LA
            STEP4:   target = 6'b001_100;  // HC, LA
            STEP5:   target = 6'b001_010;  // HC, LB
            default: target = '0;
        endcase

`ifdef DEADTIME_EN
        gates_d = gates_q;
        dt_d    = dt_q;
        if (!running) begin
            gates_d = '0;
            dt_d    = '0;
        end else if (adv || coast_q) begin
            // Masking with the present gates keeps only switches common to
            // both steps: the outgoing one drops now, the incoming one (and
            // any still-pending one from an interrupted countdown) waits.
            gates_d = gates_q & target;
            dt_d    = DEAD;
        end else if (dt_q != '0) begin
            dt_d    = dt_q - 8'd1;
            gates_d = (dt_q == 8'd1) ? target : (gates_q & target);
        end else begin
            gates_d = target;
        end
`else
        gates_d = running ? target : '0;
`endif
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speed_q     <= '0;
            acc_q       <= '0;
            step_q      <= STEP0;
            gates_q     <= '0;
            step_tick_q <= 1'b0;
            rev_tick_q  <= 1'b0;
        end else begin
            if (bus.speed_load) begin
                speed_q <= bus.speed_in;
            end
            acc_q       <= acc_d;
            step_q      <= step_d;
            gates_q     <= gates_d;
            step_tick_q <= adv;
            rev_tick_q  <= adv && (step_d == STEP0);
        end
    end

`ifdef DEADTIME_EN
    // coast_q marks the first running clock after coast so the held step's
    // switches get the dead-time treatment too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dt_q    <= '0;
            coast_q <= 1'b1;
        end else begin
            dt_q    <= dt_d;
            coast_q <= !running;
        end
    end
`endif

    assign bus.HA        = gates_q[5];
    assign bus.HB        = gates_q[4];
    assign bus.HC        = gates_q[3];
    assign bus.LA        = gates_q[2];
    assign bus.LB        = gates_q[1];
    assign bus.LC        = gates_q[0];
    assign bus.step      = step_q;
    assign bus.step_tick = step_tick_q;
    assign bus.rev_tick  = rev_tick_q;

endmodule

// File: tb/tb_commutation_generator.sv
// ---------------------------------------------------------------------------
// tb_commutation_generator
//   Scoreboard bench: the stimulus thread pushes the expected step, rev_tick,
//   gate pattern and tick interval for each advance; the monitor pops and
//   compares on every step_tick. Coast, resume, speed change and
//   asynchronous reset are checked directly by the stimulus thread.
//   CLK_HZ = 600 so speed 1 gives one step every 100 clocks.
// ---------------------------------------------------------------------------
module tb_commutation_generator;

    localparam int CLK_HZ = 600;
    localparam int ACC_W  = 12;
    localparam int DEAD   = 5;
`ifdef DEADTIME_EN
    localparam int DLY = DEAD;
`else
    localparam int DLY = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    commutation_generator_if bus();

    commutation_generator #(
        .CLK_HZ      (CLK_HZ),
        .ACC_W       (ACC_W),
        .DEAD_CYCLES (DEAD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] step;
        logic       rev;
        logic [5:0] gates;
        int         ivl;
    } exp_t;

    exp_t       sb_q[$];
    int         vectors     = 0;
    int         miscompares = 0;
    int         ticks_seen  = 0;
    int         cyc_since   = 0;
    bit         sb_mode     = 1'b1;
    logic [2:0] last_exp    = 3'd0;
    logic [5:0] g;
    logic       safe;

    assign g = {bus.HA, bus.HB, bus.HC, bus.LA, bus.LB, bus.LC};
    assign safe = !(g[5] & g[2]) && !(g[4] & g[1]) && !(g[3] & g[0]) &&
                  ($countones(g[5:3]) <= 1) && ($countones(g[2:0]) <= 1);

    function automatic logic [5:0] pat(input logic [2:0] s);
        case (s)
            3'd0:    return 6'b100_010;
            3'd1:    return 6'b100_001;
            3'd2:    return 6'b010_001;
            3'd3:    return 6'b010_100;
            3'd4:    return 6'b001_100;
            3'd5:    return 6'b001_010;
            default: return 6'b000_000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // With dead time the incoming switch is still off on the advance edge.
    task automatic push(input logic [2:0] s, input logic rev, input int ivl);
        exp_t e;
        e.step  = s;
        e.rev   = rev;
        e.gates = (DLY > 0) ? (pat(s) & pat(last_exp)) : pat(s);
        e.ivl   = ivl;
        last_exp = s;
        sb_q.push_back(e);
    endtask

    task automatic load(input logic [7:0] v);
        bus.speed_in   = v;
        bus.speed_load = 1'b1;
        @(negedge clk);
        bus.speed_load = 1'b0;
    endtask

    task automatic wait_tick(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.step_tick && n < 400);
        if (!bus.step_tick) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no step_tick within 400 clocks", name);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            cyc_since = 0;
        end else begin
            cyc_since++;
            if (bus.rev_tick && !bus.step_tick) begin
                vectors++;
                miscompares++;
                $display("FAIL rev_without_step: rev_tick=1 step_tick=0 at step %0d", bus.step);
            end
            if (bus.step_tick) begin
                exp_t e;
                ticks_seen++;
                check("phase_safe", safe, 1'b1);
                if (sb_mode) begin
                    if (sb_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_tick: step=%0d with no expected entry", bus.step);
                    end else begin
                        e = sb_q.pop_front();
                        check("tick_step",  bus.step,     e.step);
                        check("tick_rev",   bus.rev_tick, e.rev);
                        check("tick_gates", g,            e.gates);
                        if (e.ivl != 0) check("tick_interval", cyc_since, e.ivl);
                    end
                end
                cyc_since = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int cnt;
        int n;
        logic any;

        bus.speed_in   = '0;
        bus.speed_load = 1'b0;
        bus.dir        = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_gates",     g,             6'd0);
        check("rst_step",      bus.step,      3'd0);
        check("rst_step_tick", bus.step_tick, 1'b0);
        check("rst_rev_tick",  bus.rev_tick,  1'b0);

        // forward 0->1..5->0->1->2, reverse 2->1->0->5, forward 5->0..3
        push(3'd1, 1'b0, 0);
        push(3'd2, 1'b0, 100);
        push(3'd3, 1'b0, 100);
        push(3'd4, 1'b0, 100);
        push(3'd5, 1'b0, 100);
        push(3'd0, 1'b1, 100);
        push(3'd1, 1'b0, 100);
        push(3'd2, 1'b0, 100);
        push(3'd1, 1'b0, 100);
        push(3'd0, 1'b1, 100);
        push(3'd5, 1'b0, 100);
        push(3'd0, 1'b1, 100);
        push(3'd1, 1'b0, 100);
        push(3'd2, 1'b0, 100);
        push(3'd3, 1'b0, 100);

        load(8'd1);
        wait_tick("tick_0to1");
        // LB dropped on the advance edge; LC rises DLY clocks later; HA steady
        for (int k = 0; k <= DLY; k++) begin
            if (k > 0) @(negedge clk);
            check("turn_on_LC", bus.LC, (k == DLY));
            check("held_HA",    bus.HA, 1'b1);
            check("off_LB",     bus.LB, 1'b0);
        end
        repeat (7) wait_tick("fwd");
        bus.dir = 1'b1;
        repeat (3) wait_tick("rev");
        bus.dir = 1'b0;
        repeat (4) wait_tick("fwd2");

        // Coast at step 3, then resume from the held step
        repeat (10) @(negedge clk);
        push(3'd4, 1'b0, 0);
        load(8'd0);
        @(negedge clk);
        check("coast_gates", g,        6'd0);
        check("coast_step",  bus.step, 3'd3);
        #1 t0 = ticks_seen;
        repeat (200) @(negedge clk);
        #1;
        check("coast_no_ticks",   ticks_seen, t0);
        check("coast_step_held",  bus.step,   3'd3);
        check("coast_gates_held", g,          6'd0);

        load(8'd1);
        for (int k = 0; k <= DLY; k++) begin
            if (k > 0) @(negedge clk);
            check("resume_hold", g, 6'd0);
        end
        @(negedge clk);
        check("resume_gates", g,        pat(3'd3));
        check("resume_step",  bus.step, 3'd3);
        wait_tick("resume_tick");
        @(negedge clk);
        sb_mode = 1'b0;
        check("sb_drained", sb_q.size(), 0);

        // Speed change 1 -> 7 without clearing acc: 42 steps per 600 clocks
        repeat (30) @(negedge clk);
        load(8'd7);
        #1 t0 = ticks_seen;
        repeat (600) @(negedge clk);
        #1 cnt = ticks_seen - t0;
        vectors++;
        if (cnt < 41 || cnt > 43) begin
            miscompares++;
            $display("FAIL speed7_rate: got %0d ticks in 600 clocks expected 42 +/- 1", cnt);
        end

        // Asynchronous reset while HB is on
        load(8'd1);
        n = 0;
        while (!bus.HB && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("hb_reached", bus.HB, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_gates", g,             6'd0);
        check("async_rst_step",  bus.step,      3'd0);
        check("async_rst_tick",  bus.step_tick, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        any = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (g != 6'd0 || bus.step != 3'd0) any = 1'b1;
        end
        check("post_rst_idle", any, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/commutation_generator.md
# commutation_generator

Six-step BLDC gate-pattern generator that drives the six bridge switch commands (HA, HB, HC, LA, LB, LC) at a commanded mechanical speed in revolutions per second. It is the drive-side counterpart of the speed measurement path. Its outputs can feed the power stage or be looped back into the speed calculation block for closed-loop checking. A phase accumulator produces exact average step timing without a divider. Optional dead-time insertion delays each newly enabled switch.

## Interface
- CLK_HZ, 50_000_000, clock frequency in Hz; accumulator modulus.
- ACC_W, 26, accumulator width; must satisfy CLK_HZ + 6*255 < 2^ACC_W.
- DEAD_CYCLES, 50, turn-on delay in clocks for a newly enabled switch; range 1..255; used only with DEADTIME_EN.
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- speed_in  in  8  commanded speed in rev/s; 0 means coast.
- speed_load  in  1  single-cycle strobe that captures speed_in.
- dir  in  1  rotation direction; 0 = forward, 1 = reverse.
- HA, HB, HC  out  1  high-side switch commands.
- LA, LB, LC  out  1  low-side switch commands.
- step  out  3  current commutation step, 0..5.
- step_tick  out  1  one-cycle pulse on every step advance.
- rev_tick  out  1  one-cycle pulse when step enters 0, i.e. once per revolution.

## Operation
- speed_reg is 8 bits. It loads speed_in on any clock where speed_load=1. The held value is used until the next load.
- inc = 6*speed_reg, computed as an 11-bit unsigned value with a maximum of 1530.
- acc is ACC_W bits. Each clock, sum = acc + inc.
  - If sum >= CLK_HZ: acc <= sum - CLK_HZ and the step advances.
  - Otherwise: acc <= sum.
- The average step rate is exactly 6*speed_reg per second. Six steps make one revolution.
- Step advance:
  - dir=0: step <= (step==5) ? 0 : step+1.
  - dir=1: step <= (step==0) ? 5 : step-1.
  - dir is sampled only at the advance edge.
- Step decode, with all unlisted switches at 0:
  - step 0 = HA,LB
  - step 1 = HA,LC
  - step 2 = HB,LC
  - step 3 = HB,LA
  - step 4 = HC,LA
  - step 5 = HC,LB
- Every adjacent transition changes exactly one switch: one switch turns off and one turns on. The high and low switch of the same phase are never 1 together.
- When speed_reg = 0:
  - All six outputs are 0 (coast).
  - acc and step hold.
  - No ticks are generated.
- When speed_reg becomes nonzero again, the outputs resume from the held step with the held acc.
- A speed change takes effect on inc immediately. acc is not cleared, so there is no phase jump.

## Timing
- Reset values:
  - HA, HB, HC, LA, LB, LC = 0.
  - step = 0, acc = 0, speed_reg = 0.
  - step_tick = 0, rev_tick = 0.
  - Dead-time counter = 0.
- All outputs are registered.
- speed_load sampled at edge n sets speed_reg at edge n. The first accumulation using the new value is at edge n+1.
- On the advance edge:
  - step, step_tick, and rev_tick update on the same edge.
  - The switch turning off drops on that same edge.
- Switch turning on: same edge without DEADTIME_EN; DEAD_CYCLES edges later with DEADTIME_EN.
- If speed_reg transitions 0 to nonzero (leaving coast): both switches of the held step turn on the next edge. With DEADTIME_EN they turn on after DEAD_CYCLES.
- If speed_load arrives on the advance edge, the advance uses the old inc. The new speed applies from the next clock.
- If an advance occurs during an active dead-time countdown, the countdown restarts for the new incoming switch. The previous incoming switch stays off.
- The minimum step period at CLK_HZ = 50 MHz is 32679 clocks, which always exceeds DEAD_CYCLES.
- Asserting rst mid-operation forces all outputs to 0 immediately (asynchronously) and discards the pending dead time.

## Configuration
- DEADTIME_EN, defined: an 8-bit down-counter gates the incoming switch for DEAD_CYCLES clocks after each advance and after leaving coast. The outgoing switch is never delayed.
- DEADTIME_EN, undefined: no counter. Gate outputs are a registered decode of step and the coast condition. The DEAD_CYCLES parameter is ignored.

## Test plan
- CLK_HZ=600, speed_in=1 loaded, dir=0:
  - step_tick every 100 clocks.
  - Sequence 0,1,2,3,4,5,0.
  - rev_tick every 600 clocks.
  - Output patterns match the decode list.
- CLK_HZ=600, speed 1 then load 7 mid-step: acc is not cleared. The subsequent average interval is 600/42 clocks, giving 42 step_ticks per 600 clocks ±1.
- dir toggled to 1 at step 2: the next advance goes to step 1, then 0, then 5. HA/HB/HC never overlap and no phase has high and low both set.
- DEADTIME_EN, DEAD_CYCLES=5, advance from step 0 to step 1:
  - LB drops on the advance edge.
  - LC rises exactly 5 clocks later.
  - HA is unchanged throughout.
- Load speed 0 during step 3: all outputs are 0 next edge and step stays at 3. Reload speed 1: HB and LA reassert (after dead time if enabled) with no step jump.
- rst pulse asserted between clock edges while HB=1: all outputs 0 without waiting for a clock edge. After release, step=0 and outputs stay 0 until speed is loaded.
